// File: rtl/apu_pkg.sv
// apu_pkg: shared constants for the APU tone-channel envelope / length block.
//   - default register addresses for the envelope and length registers
//   - LEN_TABLE: 5-bit length index -> 8-bit length counter load value
//   - len_lookup(): table lookup helper used on length-register writes
package apu_pkg;

  localparam logic [1:0] ADDR_ENV_DFLT = 2'd0;
  localparam logic [1:0] ADDR_LEN_DFLT = 2'd3;

  localparam logic [3:0] DECAY_MAX = 4'd15;

  localparam logic [7:0] LEN_TABLE [0:31] = '{
    8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
    8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
    8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
    8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
  };

  function automatic logic [7:0] len_lookup(input logic [4:0] idx);
    return LEN_TABLE[idx];
  endfunction

endpackage

// File: rtl/frame_tick_edge.sv
// frame_tick_edge: turns a toggling frame-counter square wave into a
// single-cycle tick on each rising edge.
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset
//   level  in  square wave from frame_counter
//   tick   out one-cycle pulse when level rises
// The history flop resets high so a level that is already high when reset
// is released is not mistaken for a rising edge.
module frame_tick_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic tick
);

  logic hist_r;

  // Previous-cycle copy of the input level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_r <= 1'b1;
    end else begin
      hist_r <= level;
    end
  end

  assign tick = level & ~hist_r;

endmodule

// File: rtl/envelope_length.sv
// envelope_length: volume envelope plus length counter for one tone channel.
//   clk         in  system clock (shared with frame_counter)
//   rst_n       in  synchronous active-low reset
//   fc_qfr_clk  in  quarter-frame square wave; rising edge steps the envelope
//   fc_hfr_clk  in  half-frame square wave; rising edge steps the length counter
//   enable      in  channel enable; low holds the length counter at zero
//   wr_en       in  register write strobe
//   wr_addr     in  register select (ADDR_ENV / ADDR_LEN)
//   wr_data     in  write data
//   volume      out 4-bit channel volume
//   active      out high while the length counter is non-zero
// All next-state values are computed from current register contents, so a
// write landing on the same cycle as a tick sees the tick use the old values.
module envelope_length
  import apu_pkg::*;
#(
  parameter logic [1:0] ADDR_ENV = ADDR_ENV_DFLT,
  parameter logic [1:0] ADDR_LEN = ADDR_LEN_DFLT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fc_qfr_clk,
  input  logic       fc_hfr_clk,
  input  logic       enable,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [3:0] volume,
  output logic       active
);

  logic       loop_r,    loop_nxt_s;
  logic       const_r,   const_nxt_s;
  logic [3:0] vol_r,     vol_nxt_s;
  logic       start_r,   start_nxt_s;
  logic [3:0] divider_r, divider_nxt_s;
  logic [3:0] decay_r,   decay_nxt_s;
  logic [7:0] length_r,  length_nxt_s;

  logic qtick_s;
  logic htick_s;
  logic env_wr_s;
  logic len_wr_s;

  frame_tick_edge u_qfr_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (fc_qfr_clk),
    .tick  (qtick_s)
  );

  frame_tick_edge u_hfr_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (fc_hfr_clk),
    .tick  (htick_s)
  );

  assign env_wr_s = wr_en & (wr_addr == ADDR_ENV);
  // Length writes only take effect while the channel is enabled.
  assign len_wr_s = wr_en & (wr_addr == ADDR_LEN) & enable;

  // Envelope register update from writes.
  always_comb begin
    loop_nxt_s  = loop_r;
    const_nxt_s = const_r;
    vol_nxt_s   = vol_r;
    if (env_wr_s) begin
      loop_nxt_s  = wr_data[5];
      const_nxt_s = wr_data[4];
      vol_nxt_s   = wr_data[3:0];
    end else begin
      loop_nxt_s  = loop_r;
    end
  end

  // Envelope divider / decay stepping and the start flag.
  always_comb begin
    start_nxt_s   = start_r;
    divider_nxt_s = divider_r;
    decay_nxt_s   = decay_r;
    if (qtick_s) begin
      if (start_r) begin
        start_nxt_s   = 1'b0;
        decay_nxt_s   = DECAY_MAX;
        divider_nxt_s = vol_r;
      end else if (divider_r == 4'd0) begin
        divider_nxt_s = vol_r;
        if (decay_r != 4'd0) begin
          decay_nxt_s = decay_r - 4'd1;
        end else if (loop_r) begin
          decay_nxt_s = DECAY_MAX;
        end else begin
          decay_nxt_s = 4'd0;
        end
      end else begin
        divider_nxt_s = divider_r - 4'd1;
      end
    end else begin
      divider_nxt_s = divider_r;
    end
    // A length write re-arms the envelope even if this cycle's tick cleared start.
    if (len_wr_s) begin
      start_nxt_s = 1'b1;
    end else begin
      start_nxt_s = start_nxt_s;
    end
  end

  // Length counter: disable beats load, load beats half-frame decrement.
  always_comb begin
    length_nxt_s = length_r;
    if (!enable) begin
      length_nxt_s = 8'd0;
    end else if (len_wr_s) begin
      length_nxt_s = len_lookup(wr_data[7:3]);
    end else if (htick_s && !loop_r && (length_r != 8'd0)) begin
      length_nxt_s = length_r - 8'd1;
    end else begin
      length_nxt_s = length_r;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loop_r    <= 1'b0;
      const_r   <= 1'b0;
      vol_r     <= 4'd0;
      start_r   <= 1'b0;
      divider_r <= 4'd0;
      decay_r   <= 4'd0;
      length_r  <= 8'd0;
    end else begin
      loop_r    <= loop_nxt_s;
      const_r   <= const_nxt_s;
      vol_r     <= vol_nxt_s;
      start_r   <= start_nxt_s;
      divider_r <= divider_nxt_s;
      decay_r   <= decay_nxt_s;
      length_r  <= length_nxt_s;
    end
  end

  // Mixer outputs straight from state; silent whenever the length has run out.
  always_comb begin
    active = (length_r != 8'd0);
    if (!active) begin
      volume = 4'd0;
    end else if (const_r) begin
      volume = vol_r;
    end else begin
      volume = decay_r;
    end
  end

endmodule

// File: tb/tb_envelope_length.sv
// Directed bench for envelope_length with a behavioural reference model that
// is compared against the outputs every cycle, plus literal spot checks.
module tb_envelope_length;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fc_qfr_clk;
  logic       fc_hfr_clk;
  logic       enable;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] volume;
  logic       active;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on = 1'b0;

  envelope_length dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fc_qfr_clk (fc_qfr_clk),
    .fc_hfr_clk (fc_hfr_clk),
    .enable     (enable),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .volume     (volume),
    .active     (active)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int lt [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                  12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};
  int m_qprev, m_hprev, m_loop, m_const, m_v, m_start, m_div, m_decay, m_len;

  always @(posedge clk) begin
    int qt, ht, o_loop, o_v, o_start, lw;
    if (!rst_n) begin
      m_qprev = 1; m_hprev = 1;
      m_loop = 0; m_const = 0; m_v = 0;
      m_start = 0; m_div = 0; m_decay = 0; m_len = 0;
    end else begin
      qt = (fc_qfr_clk && m_qprev == 0) ? 1 : 0;
      ht = (fc_hfr_clk && m_hprev == 0) ? 1 : 0;
      m_qprev = fc_qfr_clk ? 1 : 0;
      m_hprev = fc_hfr_clk ? 1 : 0;
      o_loop = m_loop; o_v = m_v; o_start = m_start;
      lw = (wr_en && wr_addr == 2'd3 && enable) ? 1 : 0;
      if (qt == 1) begin
        if (o_start == 1) begin
          m_start = 0; m_decay = 15; m_div = o_v;
        end else if (m_div == 0) begin
          m_div = o_v;
          m_decay = (m_decay > 0) ? m_decay - 1 : (o_loop == 1 ? 15 : 0);
        end else begin
          m_div = m_div - 1;
        end
      end
      if (lw == 1) m_start = 1;
      if (!enable) m_len = 0;
      else if (lw == 1) m_len = lt[wr_data[7:3]];
      else if (ht == 1 && o_loop == 0 && m_len > 0) m_len = m_len - 1;
      if (wr_en && wr_addr == 2'd0) begin
        m_loop = wr_data[5] ? 1 : 0;
        m_const = wr_data[4] ? 1 : 0;
        m_v = int'(wr_data[3:0]);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, just after each clock edge.
  always @(posedge clk) begin
    int exp_act, exp_vol;
    #1;
    if (chk_on) begin
      exp_act = (m_len != 0) ? 1 : 0;
      exp_vol = (exp_act == 1) ? ((m_const == 1) ? m_v : m_decay) : 0;
      check("model_active", int'(active), exp_act);
      check("model_volume", int'(volume), exp_vol);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic qtick();
    fc_qfr_clk = 1'b1; cyc();
    fc_qfr_clk = 1'b0; cyc();
  endtask

  task automatic htick();
    fc_hfr_clk = 1'b1; cyc();
    fc_hfr_clk = 1'b0; cyc();
  endtask

  initial begin
    rst_n = 1'b0; fc_qfr_clk = 1'b1; fc_hfr_clk = 1'b1; enable = 1'b1;
    wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'd0;

    // 1: reset with frame inputs held high across release
    cyc(); chk_on = 1'b1;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    check("reset_volume", int'(volume), 0);
    check("reset_active", int'(active), 0);
    fc_qfr_clk = 1'b0; fc_hfr_clk = 1'b0;
    cyc();

    // 2: constant volume 7, length 254
    wr(2'd0, 8'h17);
    wr(2'd3, 8'h08);
    check("const_active", int'(active), 1);
    check("const_volume", int'(volume), 7);
    for (int i = 0; i < 3; i++) qtick();
    check("const_after_q", int'(volume), 7);

    // 3: decay with V=2 (3-qtick period)
    wr(2'd0, 8'h02);
    wr(2'd3, 8'h08);
    for (int i = 1; i <= 50; i++) begin
      qtick();
      if (i == 1)  check("decay_q1",  int'(volume), 15);
      if (i == 4)  check("decay_q4",  int'(volume), 14);
      if (i == 45) check("decay_q45", int'(volume), 1);
      if (i == 46) check("decay_q46", int'(volume), 0);
      if (i == 50) check("decay_q50", int'(volume), 0);
    end

    // 4: looping decay with V=0, halted length 2
    wr(2'd0, 8'h20);
    wr(2'd3, 8'h18);
    for (int i = 1; i <= 17; i++) begin
      qtick();
      if (i == 1)  check("loop_q1",  int'(volume), 15);
      if (i == 16) check("loop_q16", int'(volume), 0);
      if (i == 17) check("loop_wrap", int'(volume), 15);
    end
    for (int i = 0; i < 10; i++) htick();
    check("halt_active", int'(active), 1);
    check("halt_volume", int'(volume), 15);

    // 5: counting length; write coincident with htick
    wr(2'd0, 8'h00);
    wr(2'd3, 8'h18);
    htick(); htick();
    check("len_expire_active", int'(active), 0);
    check("len_expire_volume", int'(volume), 0);
    wr(2'd3, 8'h18);
    htick();
    fc_hfr_clk = 1'b1; wr(2'd3, 8'h18);
    fc_hfr_clk = 1'b0; cyc();
    htick();
    check("coincide_len_1", int'(active), 1);
    htick();
    check("coincide_len_0", int'(active), 0);
    // simultaneous quarter and half frame ticks
    wr(2'd3, 8'h08);
    fc_qfr_clk = 1'b1; fc_hfr_clk = 1'b1; cyc();
    fc_qfr_clk = 1'b0; fc_hfr_clk = 1'b0; cyc();
    check("both_tick_volume", int'(volume), 15);

    // 6: enable drop, disabled write, mid-decay reset
    wr(2'd0, 8'h17);
    wr(2'd3, 8'h08);
    enable = 1'b0; cyc();
    check("disable_active", int'(active), 0);
    check("disable_volume", int'(volume), 0);
    wr(2'd3, 8'h08);
    enable = 1'b1; cyc();
    check("disabled_write", int'(active), 0);
    wr(2'd0, 8'h02);
    wr(2'd3, 8'h08);
    for (int i = 0; i < 10; i++) qtick();
    check("mid_decay", int'(volume), 12);
    rst_n = 1'b0; cyc();
    check("midrst_volume", int'(volume), 0);
    check("midrst_active", int'(active), 0);
    rst_n = 1'b1; cyc();
    wr(2'd3, 8'h08);
    check("post_rst_active", int'(active), 1);
    check("post_rst_decay", int'(volume), 0);
    qtick();
    check("post_rst_q1", int'(volume), 15);
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
